// File: rtl/stat_poll_pkg.sv
// rtl/stat_poll_pkg.sv - shared types and constants for the statistics poll controller
package stat_poll_pkg;

    typedef enum logic [1:0] {IDLE, SEL, CAP, OUT} state_t;
    typedef enum logic {SRC_HOST, SRC_SWEEP} src_t;

    // Cycles between port_select update and valid counts from the stat reader.
    localparam int CAP_LATENCY = 1;

endpackage

// File: rtl/stat_poll_ctrl_if.sv
// rtl/stat_poll_ctrl_if.sv - host request and result stream bundle for stat_poll_ctrl
interface stat_poll_ctrl_if #(
    parameter int PORT_WIDTH        = 2,
    parameter int BYTE_COUNT_WIDTH  = 32,
    parameter int FRAME_COUNT_WIDTH = 32
);
    logic                         host_req_valid;
    logic [PORT_WIDTH:0]          host_req_port;
    logic                         host_req_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [PORT_WIDTH:0]          out_port;
    logic                         out_host;
    logic                         out_err;
    logic [BYTE_COUNT_WIDTH-1:0]  out_byte_count;
    logic [FRAME_COUNT_WIDTH-1:0] out_frame_count;

    modport slave (
        input  host_req_valid, host_req_port, out_ready,
        output host_req_ready, out_valid, out_port, out_host, out_err,
               out_byte_count, out_frame_count
    );

    modport master (
        output host_req_valid, host_req_port, out_ready,
        input  host_req_ready, out_valid, out_port, out_host, out_err,
               out_byte_count, out_frame_count
    );
endinterface

// File: rtl/stat_poll_timer.sv
// rtl/stat_poll_timer.sv - sweep interval down-counter with reload and one-cycle expiry pulse
module stat_poll_timer #(
    parameter int INTERVAL_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    output logic                      expire
);
    localparam logic [INTERVAL_WIDTH-1:0] ONE = INTERVAL_WIDTH'(1);

    logic [INTERVAL_WIDTH-1:0] count_q, count_d;
    logic                      load_q, load_d;

    // Counter holds cycles remaining minus one; load_q forces a fresh load after reset.
    always_comb begin
        count_d = count_q;
        load_d  = 1'b0;
        expire  = 1'b0;
        if (!enable || interval == '0 || load_q) begin
            count_d = interval - ONE;
        end else if (count_q == '0) begin
            expire  = 1'b1;
            count_d = interval - ONE;
        end else begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            load_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            load_q  <= load_d;
        end
    end
endmodule

// File: rtl/stat_poll_ctrl.sv
// rtl/stat_poll_ctrl.sv - sequences the port-multiplexed stat reader for periodic sweeps and host reads
// Optional read-and-clear pulses on port_clear when STAT_POLL_CLEAR_ON_READ_EN is defined.
module stat_poll_ctrl
    import stat_poll_pkg::*;
#(
    parameter int PORT_COUNT        = 4,
    parameter int PORT_WIDTH        = $clog2(PORT_COUNT),
    parameter int BYTE_COUNT_WIDTH  = 32,
    parameter int FRAME_COUNT_WIDTH = 32,
    parameter int INTERVAL_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [INTERVAL_WIDTH-1:0]    interval,
    stat_poll_ctrl_if.slave              bus,
    output logic [PORT_WIDTH-1:0]        port_select,
    input  logic [BYTE_COUNT_WIDTH-1:0]  byte_count,
    input  logic [FRAME_COUNT_WIDTH-1:0] frame_count,
    output logic [PORT_COUNT-1:0]        port_clear,
    output logic                         sweep_overrun
);
    localparam logic [PORT_WIDTH:0]   PORT_LIMIT = (PORT_WIDTH + 1)'(PORT_COUNT);
    localparam logic [PORT_WIDTH-1:0] PORT_LAST  = PORT_WIDTH'(PORT_COUNT - 1);

    state_t                       state_q, state_d;
    src_t                         src_q, src_d;
    logic [1:0]                   wait_q, wait_d;
    logic [PORT_WIDTH-1:0]        psel_q, psel_d;
    logic [PORT_WIDTH:0]          oport_q, oport_d;
    logic                         err_q, err_d;
    logic [BYTE_COUNT_WIDTH-1:0]  obyte_q, obyte_d;
    logic [FRAME_COUNT_WIDTH-1:0] oframe_q, oframe_d;
    logic                         active_q, active_d;
    logic                         pending_q, pending_d;
    logic [PORT_WIDTH-1:0]        idx_q, idx_d;
    logic                         overrun_q, overrun_d;
    logic                         take_pending;
    logic [PORT_WIDTH-1:0]        sweep_port;
    logic                         sweep_expire;

    stat_poll_timer #(.INTERVAL_WIDTH(INTERVAL_WIDTH)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .interval (interval),
        .expire   (sweep_expire)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        wait_d       = wait_q;
        psel_d       = psel_q;
        oport_d      = oport_q;
        err_d        = err_q;
        obyte_d      = obyte_q;
        oframe_d     = oframe_q;
        active_d     = active_q;
        idx_d        = idx_q;
        take_pending = 1'b0;
        sweep_port   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.host_req_valid) begin
                    src_d   = SRC_HOST;
                    oport_d = bus.host_req_port;
                    if (bus.host_req_port >= PORT_LIMIT) begin
                        err_d    = 1'b1;
                        obyte_d  = '0;
                        oframe_d = '0;
                        state_d  = OUT;
                    end else begin
                        err_d   = 1'b0;
                        psel_d  = bus.host_req_port[PORT_WIDTH-1:0];
                        wait_d  = '0;
                        state_d = SEL;
                    end
                end else if (active_q || (pending_q && enable)) begin
                    take_pending = !active_q;
                    sweep_port   = active_q ? idx_q : '0;
                    idx_d        = sweep_port;
                    active_d     = 1'b1;
                    src_d        = SRC_SWEEP;
                    err_d        = 1'b0;
                    psel_d       = sweep_port;
                    oport_d      = {1'b0, sweep_port};
                    wait_d       = '0;
                    state_d      = SEL;
                end
            end
            SEL: begin
                if (int'(wait_q) + 1 >= CAP_LATENCY) state_d = CAP;
                else                                  wait_d  = wait_q + 2'd1;
            end
            CAP: begin
                obyte_d  = byte_count;
                oframe_d = frame_count;
                state_d  = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    if (src_q == SRC_SWEEP) begin
                        if (idx_q == PORT_LAST) active_d = 1'b0;
                        else                    idx_d    = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One sweep may queue behind the active one; a further expiry is an overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (take_pending) pending_d = 1'b0;
        if (sweep_expire) begin
            if (pending_q && !take_pending) overrun_d = 1'b1;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= SRC_SWEEP;
            wait_q    <= '0;
            psel_q    <= '0;
            oport_q   <= '0;
            err_q     <= 1'b0;
            obyte_q   <= '0;
            oframe_q  <= '0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            wait_q    <= wait_d;
            psel_q    <= psel_d;
            oport_q   <= oport_d;
            err_q     <= err_d;
            obyte_q   <= obyte_d;
            oframe_q  <= oframe_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef STAT_POLL_CLEAR_ON_READ_EN
    always_comb begin
        port_clear = '0;
        if (state_q == CAP) port_clear[psel_q] = 1'b1;
    end
`else
    assign port_clear = '0;
`endif

    assign bus.host_req_ready  = (state_q == IDLE) && bus.host_req_valid;
    assign bus.out_valid       = (state_q == OUT);
    assign bus.out_port        = oport_q;
    assign bus.out_host        = (src_q == SRC_HOST);
    assign bus.out_err         = err_q;
    assign bus.out_byte_count  = obyte_q;
    assign bus.out_frame_count = oframe_q;
    assign port_select         = psel_q;
    assign sweep_overrun       = overrun_q;
endmodule
